// File: rtl/w0rm_core_writeback_arbiter_pkg.sv
// Shared w0rm core constants and helpers used by the writeback arbiter and the
// register file.
package w0rm_core_writeback_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_NUM_REGISTERS = 16;
  localparam int DEFAULT_MAX_WAIT      = 4;

  // Ceiling log2, clamped to at least 1 so it can always size a vector.
  function automatic int log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

  localparam int DEFAULT_REG_ADDR_BITS = log2(DEFAULT_NUM_REGISTERS);

  localparam logic [0:0] ALU_PRI = 1'b0;
  localparam logic [0:0] MEM_PRI = 1'b1;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_MEM  = 2'd2
  } grant_e;

endpackage

// File: rtl/w0rm_core_writeback_arbiter_starve_counter.sv
// Counts consecutive cycles the memory requester was denied and raises a
// registered starve flag once MAX_WAIT losses have accumulated.
module w0rm_core_wb_starve_counter
  import w0rm_core_writeback_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic starve
);

  localparam int CNT_W = log2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             starve_q;
  logic             starve_d;

  // starve is derived from the next count so it lines up with wait_cnt_q.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr) begin
      wait_cnt_d = '0;
    end else if (inc && (wait_cnt_q != MAX_CNT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    starve_d = (wait_cnt_d >= MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

  assign starve = starve_q;

endmodule

// File: rtl/w0rm_core_writeback_arbiter.sv
// Shares the register-file write port between ALU and load writebacks with
// fixed ALU priority, a starvation override for loads, and a registered port.
module w0rm_core_writeback_arbiter
  import w0rm_core_writeback_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter  int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
  parameter  int MAX_WAIT      = DEFAULT_MAX_WAIT,
  localparam int REG_ADDR_BITS = log2(NUM_REGISTERS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_wb_valid,
  input  logic [REG_ADDR_BITS-1:0] alu_wb_addr,
  input  logic [DATA_WIDTH-1:0]    alu_wb_data,
  output logic                     alu_wb_ready,
  input  logic                     mem_wb_valid,
  input  logic [REG_ADDR_BITS-1:0] mem_wb_addr,
  input  logic [DATA_WIDTH-1:0]    mem_wb_data,
  output logic                     mem_wb_ready,
  output logic [REG_ADDR_BITS-1:0] port_write_addr,
  output logic                     port_write_enable,
  output logic [DATA_WIDTH-1:0]    port_write_data,
  output logic                     starve_active
);

  logic       starve;
  logic [0:0] prio_state;
  logic       mem_has_pri;
  grant_e     grant;

  logic [REG_ADDR_BITS-1:0] port_write_addr_q;
  logic [REG_ADDR_BITS-1:0] port_write_addr_d;
  logic                     port_write_enable_q;
  logic                     port_write_enable_d;
  logic [DATA_WIDTH-1:0]    port_write_data_q;
  logic [DATA_WIDTH-1:0]    port_write_data_d;

  w0rm_core_wb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_counter (
    .clk    (clk),
    .reset  (reset),
    .inc    (mem_wb_valid && !mem_wb_ready),
    .clr    (!mem_wb_valid || mem_wb_ready),
    .starve (starve)
  );

  assign prio_state  = starve ? MEM_PRI : ALU_PRI;
  assign mem_has_pri = (prio_state == MEM_PRI);

  // Readies stay low in reset so no transfer can be lost on a reset cycle.
  assign alu_wb_ready = !reset && alu_wb_valid && !(mem_wb_valid && mem_has_pri);
  assign mem_wb_ready = !reset && mem_wb_valid && (!alu_wb_valid || mem_has_pri);

  always_comb begin
    grant = GRANT_NONE;
    if (mem_wb_ready) begin
      grant = GRANT_MEM;
    end else if (alu_wb_ready) begin
      grant = GRANT_ALU;
    end
  end

  // Address and data hold their last value on idle cycles.
  always_comb begin
    port_write_enable_d = 1'b0;
    port_write_addr_d   = port_write_addr_q;
    port_write_data_d   = port_write_data_q;
    case (grant)
      GRANT_ALU: begin
        port_write_enable_d = 1'b1;
        port_write_addr_d   = alu_wb_addr;
        port_write_data_d   = alu_wb_data;
      end
      GRANT_MEM: begin
        port_write_enable_d = 1'b1;
        port_write_addr_d   = mem_wb_addr;
        port_write_data_d   = mem_wb_data;
      end
      default: begin
        port_write_enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_write_enable_q <= 1'b0;
      port_write_addr_q   <= '0;
      port_write_data_q   <= '0;
    end else begin
      port_write_enable_q <= port_write_enable_d;
      port_write_addr_q   <= port_write_addr_d;
      port_write_data_q   <= port_write_data_d;
    end
  end

  assign port_write_enable = port_write_enable_q;
  assign port_write_addr   = port_write_addr_q;
  assign port_write_data   = port_write_data_q;
  assign starve_active     = starve;

endmodule
